// File: rtl/ej32_pkg.sv
// ============================================================================
// Module   : ej32_pkg
// Purpose  : Shared types and helpers for the eJ32 boot-image loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ej32_pkg;

    localparam int LD_STATE_W = 2;

    // Loader sequencing: settle the ROM, stream beats, flush the pipe, idle.
    typedef enum logic [LD_STATE_W-1:0] {
        LD_WAIT  = 2'd0,
        LD_COPY  = 2'd1,
        LD_DRAIN = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_t;

    // Number of DW-byte beats needed to cover sz bytes (ceiling divide).
    function automatic int ld_beats(input int sz, input int dw);
        return (sz + dw - 1) / dw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ej32_cksum32.sv
// ============================================================================
// Module   : ej32_cksum32
// Purpose  : 32-bit modulo-sum accumulator with synchronous clear and enable.
//            'total' already includes the beat presented this cycle, so the
//            caller can compare the final sum on the same edge as the last
//            accepted write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ej32_cksum32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] total
);

    logic [31:0] acc;

    assign total = acc + (en ? din : 32'h0);

    // Accumulate accepted beats; cleared on reset or when a new load begins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= 32'h0;
        end else if (clr) begin
            acc <= 32'h0;
        end else if (en) begin
            acc <= total;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ej32_img_loader.sv
// ============================================================================
// Module   : ej32_img_loader
// Purpose  : Copies a ROM-hosted eForth image into RAM in DW-byte beats with
//            RAM back-pressure, then presents the cold-start address and
//            enables the decoder. Supports reload-on-demand from DONE.
//            Optional image checksum: define EJ32_LOADER_CKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ej32_img_loader
    import ej32_pkg::*;
#(
    parameter int          ASZ      = 17,
    parameter int          DW       = 4,
    parameter int          ROM_SZ   = 8192,
    parameter int          ROM_WAIT = 3,
    parameter int          RAM_BASE = 'h0,
    parameter int          COLD     = 'h0,
    parameter logic [31:0] CKSUM    = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reload,
    output logic            rom_re,
    output logic [ASZ-1:0]  rom_a,
    input  logic [8*DW-1:0] rom_d,
    output logic            ram_we,
    output logic [ASZ-1:0]  ram_a,
    output logic [DW-1:0]   ram_be,
    output logic [8*DW-1:0] ram_d,
    input  logic            ram_rdy,
    output logic            busy,
    output logic            done,
    output logic [ASZ-1:0]  cold_p,
    output logic            cksum_err
);

    localparam int             N         = ld_beats(ROM_SZ, DW);
    localparam int             REM       = ROM_SZ % DW;
    localparam logic [ASZ-1:0] LAST_BEAT = ASZ'(N - 1);
    localparam logic [DW-1:0]  FULL_BE   = {DW{1'b1}};
    localparam logic [DW-1:0]  LAST_BE   = (REM == 0) ? FULL_BE : (FULL_BE >> (DW - REM));
    localparam logic [ASZ-1:0] BASE_A    = ASZ'(RAM_BASE);
    localparam logic [ASZ-1:0] STEP_A    = ASZ'(DW);
    localparam logic [ASZ-1:0] COLD_A    = ASZ'(COLD);
    localparam int             CW        = (ROM_WAIT > 1) ? $clog2(ROM_WAIT + 1) : 1;
    localparam logic [CW-1:0]  WAIT_C    = CW'(ROM_WAIT);

    ld_state_t          state;
    logic [CW-1:0]      wcnt;
    logic               v1;        // ROM-return stage holds a valid beat
    logic [ASZ-1:0]     b1;        // beat index of the ROM-return stage

    logic               stall;
    logic               active;
    logic               issue;
    logic               accept;
    logic               drained;
    logic               cksum_bad;
    logic [DW-1:0]      nxt_be;
    logic [8*DW-1:0]    nxt_d;
    logic [ASZ-1:0]     nxt_a;

    assign stall   = ram_we && !ram_rdy;
    // The final WAIT cycle doubles as the first issue so that ROM_WAIT=0
    // issues beat 0 on cycle 0 without leaving the WAIT reset state.
    assign active  = (state == LD_COPY) || ((state == LD_WAIT) && (wcnt == '0));
    assign issue   = active && !stall;
    assign rom_re  = rst && issue;
    assign accept  = ram_we && ram_rdy;
    assign drained = !v1 && (!ram_we || ram_rdy);

    // Byte lanes, masked data and RAM address for the beat entering the write register.
    always_comb begin
        nxt_be = (b1 == LAST_BEAT) ? LAST_BE : FULL_BE;
        nxt_d  = '0;
        for (int i = 0; i < DW; i++) begin
            nxt_d[8*i +: 8] = nxt_be[i] ? rom_d[8*i +: 8] : 8'h00;
        end
        nxt_a  = BASE_A + (b1 * STEP_A);
    end

`ifdef EJ32_LOADER_CKSUM_EN
    logic [31:0] sum_total;

    ej32_cksum32 u_cksum (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state == LD_DONE) && reload),
        .en    (accept),
        .din   (32'(ram_d)),
        .total (sum_total)
    );

    assign cksum_bad = (sum_total != CKSUM);
`else
    assign cksum_bad = 1'b0;
`endif

    // Sequencer plus the issue / ROM-return / write pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LD_WAIT;
            wcnt      <= WAIT_C;
            rom_a     <= '0;
            v1        <= 1'b0;
            b1        <= '0;
            ram_we    <= 1'b0;
            ram_a     <= '0;
            ram_be    <= '0;
            ram_d     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            cold_p    <= '0;
            cksum_err <= 1'b0;
        end else begin
            if (!stall) begin
                v1     <= issue;
                b1     <= rom_a;
                ram_we <= v1;
                if (v1) begin
                    ram_a  <= nxt_a;
                    ram_be <= nxt_be;
                    ram_d  <= nxt_d;
                end
            end

            if (issue) begin
                if (rom_a == LAST_BEAT) begin
                    state <= LD_DRAIN;
                end else begin
                    state <= LD_COPY;
                    rom_a <= rom_a + ASZ'(1);
                end
            end

            case (state)
                LD_WAIT: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - CW'(1);
                    end
                end
                LD_DRAIN: begin
                    if (drained) begin
                        state     <= LD_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cold_p    <= COLD_A;
                        cksum_err <= cksum_bad;
                    end
                end
                LD_DONE: begin
                    if (reload) begin
                        state     <= LD_WAIT;
                        wcnt      <= WAIT_C;
                        rom_a     <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        cold_p    <= '0;
                        cksum_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ej32_img_loader.sv
// ============================================================================
// Module   : tb_ej32_img_loader
// Purpose  : Scoreboard bench for ej32_img_loader. Instance A: DW=1, 16-byte
//            image, ROM_WAIT=3. Instance B: DW=4, 10-byte image at RAM 'h100,
//            ROM_WAIT=2, deliberately wrong CKSUM (checked when
//            EJ32_LOADER_CKSUM_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ej32_img_loader;

    localparam int          A_COLD  = 'h40;
    localparam int          B_COLD  = 'h1234;
    localparam logic [31:0] A_CKSUM = 32'h0000_0088;   // 1+2+...+16
    localparam logic [31:0] B_CKSUM = 32'h0C0A_1210;   // true sum 0x0C0A120F, plus one
`ifdef EJ32_LOADER_CKSUM_EN
    localparam logic        B_ERR   = 1'b1;
`else
    localparam logic        B_ERR   = 1'b0;
`endif
    localparam int          NO_STALL = 32'h7fff_ffff;

    typedef struct { int cyc; int idx; } rd_t;
    typedef struct { int cyc; logic [31:0] a; logic [3:0] be; logic [31:0] d; } wr_t;
    typedef struct { int cyc; logic [31:0] cold; logic err; } dn_t;

    logic clk;
    int   tick = 0;
    int   tests = 0;
    int   fails = 0;

    rd_t qar[$], qbr[$];
    wr_t qaw[$], qbw[$];
    dn_t qad[$], qbd[$];

    // ---------------- instance A ----------------
    logic        rst_a, reload_a, rom_re_a, ram_we_a, ram_rdy_a, busy_a, done_a, cksum_err_a;
    logic [16:0] rom_a_a, ram_a_a, cold_p_a;
    logic [7:0]  rom_d_a, ram_d_a;
    logic [0:0]  ram_be_a;

    ej32_img_loader #(
        .ASZ(17), .DW(1), .ROM_SZ(16), .ROM_WAIT(3),
        .RAM_BASE('h0), .COLD(A_COLD), .CKSUM(A_CKSUM)
    ) dut_a (
        .clk(clk), .rst(rst_a), .reload(reload_a),
        .rom_re(rom_re_a), .rom_a(rom_a_a), .rom_d(rom_d_a),
        .ram_we(ram_we_a), .ram_a(ram_a_a), .ram_be(ram_be_a), .ram_d(ram_d_a),
        .ram_rdy(ram_rdy_a), .busy(busy_a), .done(done_a),
        .cold_p(cold_p_a), .cksum_err(cksum_err_a)
    );

    // ---------------- instance B ----------------
    logic        rst_b, reload_b, rom_re_b, ram_we_b, ram_rdy_b, busy_b, done_b, cksum_err_b;
    logic [16:0] rom_a_b, ram_a_b, cold_p_b;
    logic [31:0] rom_d_b, ram_d_b;
    logic [3:0]  ram_be_b;

    ej32_img_loader #(
        .ASZ(17), .DW(4), .ROM_SZ(10), .ROM_WAIT(2),
        .RAM_BASE('h100), .COLD(B_COLD), .CKSUM(B_CKSUM)
    ) dut_b (
        .clk(clk), .rst(rst_b), .reload(reload_b),
        .rom_re(rom_re_b), .rom_a(rom_a_b), .rom_d(rom_d_b),
        .ram_we(ram_we_b), .ram_a(ram_a_b), .ram_be(ram_be_b), .ram_d(ram_d_b),
        .ram_rdy(ram_rdy_b), .busy(busy_b), .done(done_b),
        .cold_p(cold_p_b), .cksum_err(cksum_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tick = index of the next rising edge
    always @(posedge clk) tick <= tick + 1;

    function automatic logic [31:0] rom_word_b(input logic [16:0] i);
        case (i)
            17'd0:   return 32'h0403_0201;
            17'd1:   return 32'h0807_0605;
            17'd2:   return 32'hAAAA_0A09;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // ROM models: registered read, output held while rom_re is low
    always @(posedge clk) if (rom_re_a) rom_d_a <= 8'(rom_a_a + 17'd1);
    always @(posedge clk) if (rom_re_b) rom_d_b <= rom_word_b(rom_a_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm, input int cyc);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event at cycle %0d, expected none", nm, cyc);
    endtask

    function automatic int sh(input int c, input int s, input int l);
        return (c >= s) ? c + l : c;
    endfunction

    task automatic push_a(input int base, input int s, input int l);
        for (int j = 0; j < 16; j++) begin
            qar.push_back('{sh(base + 3 + j, s, l), j});
            qaw.push_back('{sh(base + 5 + j, s, l), 32'(j), 4'h1, 32'(j + 1)});
        end
        qad.push_back('{sh(base + 21, s, l), 32'(A_COLD), 1'b0});
    endtask

    task automatic push_b(input int base);
        logic [31:0] d [3];
        logic [3:0]  be [3];
        d  = '{32'h0403_0201, 32'h0807_0605, 32'h0000_0A09};
        be = '{4'hF, 4'hF, 4'h3};
        for (int j = 0; j < 3; j++) begin
            qbr.push_back('{base + 2 + j, j});
            qbw.push_back('{base + 4 + j, 32'('h100 + 4 * j), be[j], d[j]});
        end
        qbd.push_back('{base + 7, 32'(B_COLD), B_ERR});
    endtask

    // Scoreboard monitor A
    always begin : mon_a
        rd_t r;
        wr_t w;
        dn_t d;
        logic pd;
        pd = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (rst_a) begin
                if (rom_re_a) begin
                    if (qar.size() == 0) unexpected("a_rom_issue", tick);
                    else begin
                        r = qar.pop_front();
                        chk("a_rom_cycle", 32'(tick), 32'(r.cyc));
                        chk("a_rom_a", 32'(rom_a_a), 32'(r.idx));
                    end
                end
                if (ram_we_a && ram_rdy_a) begin
                    if (qaw.size() == 0) unexpected("a_ram_write", tick);
                    else begin
                        w = qaw.pop_front();
                        chk("a_wr_cycle", 32'(tick), 32'(w.cyc));
                        chk("a_wr_addr", 32'(ram_a_a), w.a);
                        chk("a_wr_be", 32'(ram_be_a), 32'(w.be));
                        chk("a_wr_data", 32'(ram_d_a), w.d);
                    end
                end
                if (done_a && !pd) begin
                    if (qad.size() == 0) unexpected("a_done", tick);
                    else begin
                        d = qad.pop_front();
                        chk("a_done_cycle", 32'(tick), 32'(d.cyc));
                        chk("a_cold_p", 32'(cold_p_a), d.cold);
                        chk("a_busy_at_done", 32'(busy_a), 32'd0);
                        chk("a_cksum_err", 32'(cksum_err_a), 32'(d.err));
                    end
                end
                pd = done_a;
            end else begin
                pd = 1'b0;
            end
        end
    end

    // Scoreboard monitor B
    always begin : mon_b
        rd_t r;
        wr_t w;
        dn_t d;
        logic pd;
        pd = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (rst_b) begin
                if (rom_re_b) begin
                    if (qbr.size() == 0) unexpected("b_rom_issue", tick);
                    else begin
                        r = qbr.pop_front();
                        chk("b_rom_cycle", 32'(tick), 32'(r.cyc));
                        chk("b_rom_a", 32'(rom_a_b), 32'(r.idx));
                    end
                end
                if (ram_we_b && ram_rdy_b) begin
                    if (qbw.size() == 0) unexpected("b_ram_write", tick);
                    else begin
                        w = qbw.pop_front();
                        chk("b_wr_cycle", 32'(tick), 32'(w.cyc));
                        chk("b_wr_addr", 32'(ram_a_b), w.a);
                        chk("b_wr_be", 32'(ram_be_b), 32'(w.be));
                        chk("b_wr_data", ram_d_b, w.d);
                    end
                end
                if (done_b && !pd) begin
                    if (qbd.size() == 0) unexpected("b_done", tick);
                    else begin
                        d = qbd.pop_front();
                        chk("b_done_cycle", 32'(tick), 32'(d.cyc));
                        chk("b_cold_p", 32'(cold_p_b), d.cold);
                        chk("b_busy_at_done", 32'(busy_b), 32'd0);
                        chk("b_cksum_err", 32'(cksum_err_b), 32'(d.err));
                    end
                end
                pd = done_b;
            end else begin
                pd = 1'b0;
            end
        end
    end

    task automatic check_reset_a(input string tag);
        chk({tag, "_rom_re"}, 32'(rom_re_a), 32'd0);
        chk({tag, "_rom_a"}, 32'(rom_a_a), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we_a), 32'd0);
        chk({tag, "_ram_a"}, 32'(ram_a_a), 32'd0);
        chk({tag, "_ram_be"}, 32'(ram_be_a), 32'd0);
        chk({tag, "_ram_d"}, 32'(ram_d_a), 32'd0);
        chk({tag, "_busy"}, 32'(busy_a), 32'd1);
        chk({tag, "_done"}, 32'(done_a), 32'd0);
        chk({tag, "_cold_p"}, 32'(cold_p_a), 32'd0);
        chk({tag, "_cksum_err"}, 32'(cksum_err_a), 32'd0);
    endtask

    task automatic wait_a(input string tag);
        int k = 0;
        while (qad.size() != 0 && k < 80) begin
            @(negedge clk); #2;
            k++;
        end
        chk({tag, "_done_pending"}, 32'(qad.size()), 32'd0);
        chk({tag, "_writes_left"}, 32'(qaw.size()), 32'd0);
        chk({tag, "_issues_left"}, 32'(qar.size()), 32'd0);
    endtask

    task automatic wait_b(input string tag);
        int k = 0;
        while (qbd.size() != 0 && k < 80) begin
            @(negedge clk); #2;
            k++;
        end
        chk({tag, "_done_pending"}, 32'(qbd.size()), 32'd0);
        chk({tag, "_writes_left"}, 32'(qbw.size()), 32'd0);
        chk({tag, "_issues_left"}, 32'(qbr.size()), 32'd0);
    endtask

    task automatic reload_pulse_a(output int base);
        @(negedge clk);
        reload_a = 1'b1;
        base = tick + 1;
        @(negedge clk);
        reload_a = 1'b0;
        #1;
        chk("a_reload_done_drop", 32'(done_a), 32'd0);
        chk("a_reload_busy", 32'(busy_a), 32'd1);
    endtask

    task automatic seq_a();
        int base;
        rst_a = 1'b0; reload_a = 1'b0; ram_rdy_a = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset_a("a_por");
        // plain copy
        @(negedge clk);
        rst_a = 1'b1;
        base = tick;
        push_a(base, NO_STALL, 0);
        wait_a("a_run1");
        // reload, with ram_rdy low on cycles 10..13
        reload_pulse_a(base);
        push_a(base, base + 10, 4);
        while (tick != base + 10) @(negedge clk);
        ram_rdy_a = 1'b0;
        #1;
        chk("a_stall_rom_re", 32'(rom_re_a), 32'd0);
        chk("a_stall_rom_a", 32'(rom_a_a), 32'd7);
        chk("a_stall_ram_a", 32'(ram_a_a), 32'd5);
        chk("a_stall_ram_d", 32'(ram_d_a), 32'd6);
        repeat (3) @(negedge clk);
        #1;
        chk("a_stall_end_rom_a", 32'(rom_a_a), 32'd7);
        chk("a_stall_end_ram_d", 32'(ram_d_a), 32'd6);
        @(negedge clk);
        ram_rdy_a = 1'b1;
        wait_a("a_stall");
        // reload, then reset while beat 5 is issued
        reload_pulse_a(base);
        push_a(base, NO_STALL, 0);
        while (tick != base + 8) @(negedge clk);
        rst_a = 1'b0;
        #1 check_reset_a("a_midrst");
        qar.delete(); qaw.delete(); qad.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        base = tick;
        push_a(base, NO_STALL, 0);
        wait_a("a_restart");
    endtask

    task automatic seq_b();
        int base;
        rst_b = 1'b0; reload_b = 1'b0; ram_rdy_b = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("b_por_busy", 32'(busy_b), 32'd1);
        chk("b_por_ram_we", 32'(ram_we_b), 32'd0);
        chk("b_por_rom_re", 32'(rom_re_b), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        base = tick;
        push_b(base);
        wait_b("b_run1");
        repeat (3) @(negedge clk);
        #1 chk("b_cksum_sticky", 32'(cksum_err_b), 32'(B_ERR));
        // reload from DONE
        @(negedge clk);
        reload_b = 1'b1;
        base = tick + 1;
        push_b(base);
        @(negedge clk);
        reload_b = 1'b0;
        #1;
        chk("b_reload_done_drop", 32'(done_b), 32'd0);
        chk("b_reload_cksum_clr", 32'(cksum_err_b), 32'd0);
        chk("b_reload_cold_p", 32'(cold_p_b), 32'd0);
        // a reload pulse during COPY must be ignored
        while (tick != base + 3) @(negedge clk);
        reload_b = 1'b1;
        @(negedge clk);
        reload_b = 1'b0;
        wait_b("b_run2");
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
